// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: programmable LEN-symbol sequence detector.
// It tracks how many leading elements of the pattern have been matched.
// In repeat mode the most recently matched symbol may repeat without
// breaking the match.
// It produces a one-cycle entry pulse and a saturating count of entries.
//
// Input handshake: in_valid qualifies in_sym. There is no ready signal,
// so the block always accepts a symbol in any cycle where in_valid is
// high. Cycles where in_valid is low do not change the stage.
module seq_pattern_detector #(
  parameter int SYM_W = 2,
  parameter int LEN   = 3,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [SYM_W-1:0]         in_sym,
  input  logic [LEN*SYM_W-1:0]     pattern,
  input  logic                     allow_repeat,
  input  logic                     clear_cnt,
  output logic [$clog2(LEN+1)-1:0] stage,
  output logic                     match,
  output logic                     match_pulse,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int ST_W = $clog2(LEN + 1);
  localparam logic [ST_W-1:0]  LEN_ST  = ST_W'(LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYM_W-1:0] pat [LEN];
  logic [SYM_W-1:0] cur_el;    // element that would be matched next
  logic [SYM_W-1:0] prev_el;   // element matched most recently
  logic [ST_W-1:0]  next_stage;
  logic             at_len;
  logic             entry;

  // Unpack the flat pattern bus into one element per array slot.
  always_comb begin
    for (int k = 0; k < LEN; k++) begin
      pat[k] = pattern[k*SYM_W +: SYM_W];
    end
  end

  // Select the current and previous elements, then apply the next-stage rules in priority order.
  always_comb begin
    cur_el  = '0;
    prev_el = '0;
    for (int k = 0; k < LEN; k++) begin
      if (stage == ST_W'(k))     cur_el  = pat[k];
      if (stage == ST_W'(k + 1)) prev_el = pat[k];
    end
    at_len = (stage == LEN_ST);
    if (!at_len && in_sym == cur_el) begin
      next_stage = stage + ST_W'(1);          // advance
    end else if (allow_repeat && stage != '0 && in_sym == prev_el) begin
      next_stage = stage;                     // hold on a repeated symbol
    end else if (in_sym == pat[0]) begin
      next_stage = ST_W'(1);                  // restart on the first element
    end else begin
      next_stage = '0;
    end
    // Entry into LEN only happens from below LEN. Staying at LEN does not count.
    entry = in_valid && (next_stage == LEN_ST) && !at_len;
  end

  assign match = (stage == LEN_ST);

  // Register the stage, the entry pulse and the saturating counter. Reset has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage       <= '0;
      match_pulse <= 1'b0;
      match_cnt   <= '0;
    end else begin
      if (in_valid) stage <= next_stage;
      match_pulse <= entry;
      // A clear in the same cycle as an entry drops that entry from the count.
      if (clear_cnt) begin
        match_cnt <= '0;
      end else if (entry && match_cnt != CNT_MAX) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Testbench for seq_pattern_detector.
// It uses a vector table for the default configuration.
// Hand-written sequences cover the LEN=4 and CNT_W=2 variants.
module tb_seq_pattern_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- dut0: defaults (SYM_W=2, LEN=3, CNT_W=8) ----------------
  logic       d0_reset, d0_valid, d0_rep, d0_clr;
  logic [1:0] d0_sym;
  logic [5:0] d0_pat;
  logic [1:0] d0_stage;
  logic       d0_match, d0_pulse;
  logic [7:0] d0_cnt;

  seq_pattern_detector dut0 (
    .clk(clk), .reset(d0_reset), .in_valid(d0_valid), .in_sym(d0_sym),
    .pattern(d0_pat), .allow_repeat(d0_rep), .clear_cnt(d0_clr),
    .stage(d0_stage), .match(d0_match), .match_pulse(d0_pulse), .match_cnt(d0_cnt)
  );

  // ---------------- dut1: SYM_W=3, LEN=4 ----------------
  logic        d1_reset, d1_valid, d1_rep, d1_clr;
  logic [2:0]  d1_sym;
  logic [11:0] d1_pat;
  logic [2:0]  d1_stage;
  logic        d1_match, d1_pulse;
  logic [7:0]  d1_cnt;

  seq_pattern_detector #(.SYM_W(3), .LEN(4), .CNT_W(8)) dut1 (
    .clk(clk), .reset(d1_reset), .in_valid(d1_valid), .in_sym(d1_sym),
    .pattern(d1_pat), .allow_repeat(d1_rep), .clear_cnt(d1_clr),
    .stage(d1_stage), .match(d1_match), .match_pulse(d1_pulse), .match_cnt(d1_cnt)
  );

  // ---------------- dut2: CNT_W=2 ----------------
  logic       d2_reset, d2_valid, d2_rep, d2_clr;
  logic [1:0] d2_sym;
  logic [5:0] d2_pat;
  logic [1:0] d2_stage;
  logic       d2_match, d2_pulse;
  logic [1:0] d2_cnt;

  seq_pattern_detector #(.SYM_W(2), .LEN(3), .CNT_W(2)) dut2 (
    .clk(clk), .reset(d2_reset), .in_valid(d2_valid), .in_sym(d2_sym),
    .pattern(d2_pat), .allow_repeat(d2_rep), .clear_cnt(d2_clr),
    .stage(d2_stage), .match(d2_match), .match_pulse(d2_pulse), .match_cnt(d2_cnt)
  );

  // ---------------- checker ----------------
  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // ---------------- vector table for dut0 ----------------
  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] sym;
    logic       rep;
    logic       clr;
    int         st;
    logic       m;
    logic       p;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic vld, input logic [1:0] sym,
                     input logic rep, input logic clr,
                     input int st, input logic m, input logic p, input int cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.sym = sym; v.rep = rep; v.clr = clr;
    v.st = st; v.m = m; v.p = p; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    // Idle values for every DUT.
    d0_reset = 1'b1; d0_valid = 1'b0; d0_sym = '0; d0_rep = 1'b1; d0_clr = 1'b0;
    d0_pat   = {2'd3, 2'd2, 2'd1};
    d1_reset = 1'b1; d1_valid = 1'b0; d1_sym = '0; d1_rep = 1'b0; d1_clr = 1'b0;
    d1_pat   = {3'd1, 3'd7, 3'd5, 3'd5};
    d2_reset = 1'b1; d2_valid = 1'b0; d2_sym = '0; d2_rep = 1'b1; d2_clr = 1'b0;
    d2_pat   = {2'd3, 2'd2, 2'd1};

    //   rst vld sym rep clr   st m p cnt
    // Test 1: repeat mode, stream 1,2,2,3,3,1,0
    add(1, 0, 0, 1, 0,        0, 0, 0, 0);
    add(0, 1, 1, 1, 0,        1, 0, 0, 0);
    add(0, 1, 2, 1, 0,        2, 0, 0, 0);
    add(0, 1, 2, 1, 0,        2, 0, 0, 0);
    add(0, 1, 3, 1, 0,        3, 1, 1, 1);
    add(0, 1, 3, 1, 0,        3, 1, 0, 1);
    add(0, 1, 1, 1, 0,        1, 0, 0, 1);
    add(0, 1, 0, 1, 0,        0, 0, 0, 1);
    // Test 2: strict mode, stream 1,2,2,3 then 1,2,3
    add(1, 0, 0, 0, 0,        0, 0, 0, 0);
    add(0, 1, 1, 0, 0,        1, 0, 0, 0);
    add(0, 1, 2, 0, 0,        2, 0, 0, 0);
    add(0, 1, 2, 0, 0,        0, 0, 0, 0);
    add(0, 1, 3, 0, 0,        0, 0, 0, 0);
    add(0, 1, 1, 0, 0,        1, 0, 0, 0);
    add(0, 1, 2, 0, 0,        2, 0, 0, 0);
    add(0, 1, 3, 0, 0,        3, 1, 1, 1);
    // Test 3: in_valid gaps
    add(1, 0, 0, 1, 0,        0, 0, 0, 0);
    add(0, 1, 1, 1, 0,        1, 0, 0, 0);
    add(0, 0, 0, 1, 0,        1, 0, 0, 0);
    add(0, 0, 0, 1, 0,        1, 0, 0, 0);
    add(0, 0, 0, 1, 0,        1, 0, 0, 0);
    add(0, 1, 2, 1, 0,        2, 0, 0, 0);
    add(0, 0, 0, 1, 0,        2, 0, 0, 0);
    add(0, 1, 3, 1, 0,        3, 1, 1, 1);
    add(0, 0, 0, 1, 0,        3, 1, 0, 1);
    add(0, 0, 0, 1, 1,        3, 1, 0, 0);   // clear while idle
    // Test 6: reset mid-match
    add(1, 0, 0, 1, 0,        0, 0, 0, 0);
    add(0, 1, 1, 1, 0,        1, 0, 0, 0);
    add(0, 1, 2, 1, 0,        2, 0, 0, 0);
    add(0, 1, 3, 1, 0,        3, 1, 1, 1);
    add(0, 1, 1, 1, 0,        1, 0, 0, 1);
    add(0, 1, 2, 1, 0,        2, 0, 0, 1);
    add(1, 0, 0, 1, 0,        0, 0, 0, 0);   // reset at stage 2
    add(0, 1, 1, 1, 0,        1, 0, 0, 0);
    add(0, 1, 2, 1, 0,        2, 0, 0, 0);
    add(1, 1, 3, 1, 0,        0, 0, 0, 0);   // reset with entry symbol
    add(0, 0, 0, 1, 0,        0, 0, 0, 0);

    // Release the other DUTs from reset during the first table row.
    @(posedge clk); #1;
    d1_reset = 1'b0; d2_reset = 1'b0;

    foreach (vecs[i]) begin
      d0_reset = vecs[i].rst; d0_valid = vecs[i].vld; d0_sym = vecs[i].sym;
      d0_rep   = vecs[i].rep; d0_clr   = vecs[i].clr;
      @(posedge clk); #1;
      chk("d0_stage", i, int'(d0_stage), vecs[i].st);
      chk("d0_match", i, int'(d0_match), int'(vecs[i].m));
      chk("d0_pulse", i, int'(d0_pulse), int'(vecs[i].p));
      chk("d0_cnt",   i, int'(d0_cnt),   vecs[i].cnt);
    end
    d0_valid = 1'b0; d0_reset = 1'b0;

    // Test 4: LEN=4, pattern 5,5,7,1, strict mode; advance beats restart.
    begin
      logic [2:0] s4 [9];
      int         e4 [9];
      s4 = '{3'd5, 3'd5, 3'd5, 3'd7, 3'd1, 3'd5, 3'd5, 3'd7, 3'd1};
      e4 = '{1, 2, 1, 0, 0, 1, 2, 3, 4};
      for (int i = 0; i < 9; i++) begin
        d1_valid = 1'b1; d1_sym = s4[i];
        @(posedge clk); #1;
        chk("d1_stage", i, int'(d1_stage), e4[i]);
      end
      d1_valid = 1'b0;
      chk("d1_match", 9, int'(d1_match), 1);
      chk("d1_pulse", 9, int'(d1_pulse), 1);
      chk("d1_cnt",   9, int'(d1_cnt),   1);
    end

    // Test 5: CNT_W=2, saturating count, then clear beats the seventh entry.
    begin
      logic [1:0] s5 [4];
      int         ec [6];
      s5 = '{2'd1, 2'd2, 2'd3, 2'd0};
      ec = '{1, 2, 3, 3, 3, 3};
      for (int r = 0; r < 6; r++) begin
        for (int j = 0; j < 4; j++) begin
          d2_valid = 1'b1; d2_sym = s5[j];
          @(posedge clk); #1;
          if (j == 2) begin
            chk("d2_pulse", r, int'(d2_pulse), 1);
            chk("d2_cnt",   r, int'(d2_cnt),   ec[r]);
          end
        end
      end
      d2_sym = 2'd1; @(posedge clk); #1;
      d2_sym = 2'd2; @(posedge clk); #1;
      d2_sym = 2'd3; d2_clr = 1'b1; @(posedge clk); #1;
      chk("d2_clr_cnt",   6, int'(d2_cnt),   0);
      chk("d2_clr_pulse", 6, int'(d2_pulse), 1);
      chk("d2_clr_stage", 6, int'(d2_stage), 3);
      d2_clr = 1'b0; d2_sym = 2'd0; @(posedge clk); #1;
      chk("d2_post_cnt",   7, int'(d2_cnt),   0);
      chk("d2_post_pulse", 7, int'(d2_pulse), 0);
      d2_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
